// File: rtl/collision_pkg.sv
// Shared definitions for the smiley collision path: edge bit positions, FSM state type and
// default object geometry.
package collision_pkg;

  // Bit positions inside the 4-bit {Left, Top, Right, Bottom} edge code.
  localparam int unsigned LEFT   = 3;
  localparam int unsigned TOP    = 2;
  localparam int unsigned RIGHT  = 1;
  localparam int unsigned BOTTOM = 0;

  localparam int unsigned DefaultObjectWidth  = 32;
  localparam int unsigned DefaultObjectHeight = 32;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLDOFF
  } hit_state_t;

endpackage

// File: rtl/smiley_hit_detector_if.sv
// Pixel-stream and collision-report bundle between the VGA object blocks, the hit detector
// and the smiley motion block.
interface smiley_hit_detector_if;

  logic               startOfFrame;
  logic signed [10:0] offsetX;
  logic signed [10:0] offsetY;
  logic               smileyDrawingRequest;
  logic               brickDrawingRequest;
  logic               collision;
  logic [3:0]         HitEdgeCode;

  modport master (
    output startOfFrame,
    output offsetX,
    output offsetY,
    output smileyDrawingRequest,
    output brickDrawingRequest,
    input  collision,
    input  HitEdgeCode
  );

  modport slave (
    input  startOfFrame,
    input  offsetX,
    input  offsetY,
    input  smileyDrawingRequest,
    input  brickDrawingRequest,
    output collision,
    output HitEdgeCode
  );

endinterface

// File: rtl/edge_zone_classifier.sv
// Maps a pixel offset relative to the smiley's top-left corner onto the edge zones it touches.
// Pixels outside the smiley bounding box yield a zero code and a cleared in-range flag.
module edge_zone_classifier
  import collision_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH  = DefaultObjectWidth,
  parameter int unsigned OBJECT_HEIGHT = DefaultObjectHeight,
  parameter int unsigned EDGE_WIDTH    = 4
) (
  input  logic signed [10:0] offset_x_i,
  input  logic signed [10:0] offset_y_i,
  output logic [3:0]         code_o,
  output logic               in_range_o
);

  localparam logic signed [10:0] Width     = 11'(OBJECT_WIDTH);
  localparam logic signed [10:0] Height    = 11'(OBJECT_HEIGHT);
  localparam logic signed [10:0] EdgeW     = 11'(EDGE_WIDTH);
  localparam logic signed [10:0] RightLim  = 11'(OBJECT_WIDTH - EDGE_WIDTH);
  localparam logic signed [10:0] BottomLim = 11'(OBJECT_HEIGHT - EDGE_WIDTH);

  logic [3:0] raw_code;

  always_comb begin
    in_range_o = !offset_x_i[10] && !offset_y_i[10] &&
                 (offset_x_i < Width) && (offset_y_i < Height);

    raw_code         = '0;
    raw_code[LEFT]   = offset_x_i < EdgeW;
    raw_code[TOP]    = offset_y_i < EdgeW;
    raw_code[RIGHT]  = offset_x_i >= RightLim;
    raw_code[BOTTOM] = offset_y_i >= BottomLim;

    code_o = in_range_o ? raw_code : 4'b0000;
  end

endmodule

// File: rtl/smiley_hit_detector.sv
// Accumulates smiley/brick overlap edge codes over a frame and reports them as a one-cycle
// collision pulse with a held edge code at the next start of frame, with optional hold-off.
module smiley_hit_detector
  import collision_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH   = DefaultObjectWidth,
  parameter int unsigned OBJECT_HEIGHT  = DefaultObjectHeight,
  parameter int unsigned EDGE_WIDTH     = 4,
  parameter int unsigned HOLDOFF_FRAMES = 2
) (
  input logic                 clk,
  input logic                 resetN,
  smiley_hit_detector_if.slave bus
);

  localparam int unsigned CntW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLDOFF_FRAMES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  hit_state_t      state_q, state_d;
  logic [3:0]      acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            collision_q, collision_d;
  logic [3:0]      code_q, code_d;

  logic [3:0] zone_code;
  logic       in_range;
  logic [3:0] pix_code;
  logic [3:0] final_acc;

  edge_zone_classifier #(
    .OBJECT_WIDTH  (OBJECT_WIDTH),
    .OBJECT_HEIGHT (OBJECT_HEIGHT),
    .EDGE_WIDTH    (EDGE_WIDTH)
  ) u_classifier (
    .offset_x_i (bus.offsetX),
    .offset_y_i (bus.offsetY),
    .code_o     (zone_code),
    .in_range_o (in_range)
  );

  always_comb begin
    pix_code  = (bus.smileyDrawingRequest && bus.brickDrawingRequest && in_range) ?
                zone_code : 4'b0000;
    // The pixel sampled alongside startOfFrame still belongs to the ending frame.
    final_acc = acc_q | pix_code;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = final_acc;
    cnt_d       = cnt_q;
    collision_d = 1'b0;
    code_d      = code_q;

    unique case (state_q)
      IDLE: begin
        acc_d = 4'b0000;
        if (bus.startOfFrame) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.startOfFrame) begin
          acc_d = 4'b0000;
          if (final_acc != 4'b0000) begin
            collision_d = 1'b1;
            code_d      = final_acc;
            if (HOLDOFF_FRAMES != 0) begin
              state_d = HOLDOFF;
              cnt_d   = CntLoad;
            end
          end
        end
      end
      HOLDOFF: begin
        if (bus.startOfFrame) begin
          acc_d = 4'b0000;
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = SCAN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      acc_q       <= 4'b0000;
      cnt_q       <= '0;
      collision_q <= 1'b0;
      code_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      collision_q <= collision_d;
      code_q      <= code_d;
    end
  end

  assign bus.collision   = collision_q;
  assign bus.HitEdgeCode = code_q;

endmodule

// File: tb/tb_smiley_hit_detector.sv
// Directed bench for smiley_hit_detector with default geometry (32x32, edge 4, hold-off 2).
module tb_smiley_hit_detector;

  logic clk;
  logic resetN;
  int   checks;
  int   fails;

  smiley_hit_detector_if bus ();

  smiley_hit_detector #(
    .OBJECT_WIDTH   (32),
    .OBJECT_HEIGHT  (32),
    .EDGE_WIDTH     (4),
    .HOLDOFF_FRAMES (2)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int x, input int y, input bit s, input bit b, input bit sof);
    bus.offsetX              = 11'(x);
    bus.offsetY              = 11'(y);
    bus.smileyDrawingRequest = s;
    bus.brickDrawingRequest  = b;
    bus.startOfFrame         = sof;
  endtask

  task automatic idle();
    drive(-1, -1, 1'b0, 1'b0, 1'b0);
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input int x, input int y);
    drive(x, y, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    tick();
  endtask

  task automatic sof_tick(output bit pulse);
    drive(-1, -1, 1'b0, 1'b0, 1'b1);
    tick();
    pulse = bus.collision;
    idle();
  endtask

  task automatic do_reset();
    idle();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic start_scan();
    bit p;
    do_reset();
    hit(0, 10);
    sof_tick(p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL start_scan_no_pulse: collision=%b required=0", p);
      fails++;
    end
  endtask

  task automatic test_reset();
    idle();
    resetN = 1'b0;
    tick();
    checks++;
    if (bus.collision !== 1'b0) begin
      $display("FAIL reset_collision: got=%b required=0", bus.collision);
      fails++;
    end
    checks++;
    if (bus.HitEdgeCode !== 4'b0000) begin
      $display("FAIL reset_code: got=%b required=0000", bus.HitEdgeCode);
      fails++;
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_first_report();
    bit p;
    start_scan();
    hit(0, 10);
    sof_tick(p);
    checks++;
    if (p !== 1'b1) begin
      $display("FAIL left_pulse: collision=%b required=1", p);
      fails++;
    end
    checks++;
    if (bus.HitEdgeCode !== 4'b1000) begin
      $display("FAIL left_code: got=%b required=1000", bus.HitEdgeCode);
      fails++;
    end
    tick();
    checks++;
    if (bus.collision !== 1'b0) begin
      $display("FAIL pulse_width: collision=%b required=0", bus.collision);
      fails++;
    end
  endtask

  task automatic test_corners_and_misses();
    bit p;
    start_scan();
    hit(31, 0);
    hit(15, 31);
    sof_tick(p);
    checks++;
    if (p !== 1'b1 || bus.HitEdgeCode !== 4'b0111) begin
      $display("FAIL combo_report: collision=%b code=%b required=1/0111", p, bus.HitEdgeCode);
      fails++;
    end
    tick();
    checks++;
    if (bus.collision !== 1'b0) begin
      $display("FAIL combo_single: collision=%b required=0", bus.collision);
      fails++;
    end
    // Two hold-off frames, then frames with only non-reportable overlaps.
    for (int i = 0; i < 6; i++) begin
      case (i)
        2: hit(15, 15);
        3: begin drive(0, 0, 1'b0, 1'b1, 1'b0); tick(); idle(); end
        4: begin hit(32, 0); hit(-1, 5); end
        5: begin hit(4, 27); hit(27, 4); end
        default: idle();
      endcase
      sof_tick(p);
      checks++;
      if (p !== 1'b0 || bus.HitEdgeCode !== 4'b0111) begin
        $display("FAIL miss_frame%0d: collision=%b code=%b required=0/0111", i, p,
                 bus.HitEdgeCode);
        fails++;
      end
    end
  endtask

  task automatic test_holdoff();
    bit p;
    bit exp_p;
    start_scan();
    for (int i = 1; i <= 7; i++) begin
      hit(10, 30);
      sof_tick(p);
      exp_p = (i == 1) || (i == 4) || (i == 7);
      checks++;
      if (p !== exp_p) begin
        $display("FAIL holdoff_sof%0d: collision=%b required=%b", i, p, exp_p);
        fails++;
      end
    end
    checks++;
    if (bus.HitEdgeCode !== 4'b0001) begin
      $display("FAIL holdoff_code: got=%b required=0001", bus.HitEdgeCode);
      fails++;
    end
  endtask

  task automatic test_sof_pixel();
    start_scan();
    drive(0, 0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    checks++;
    if (bus.collision !== 1'b1 || bus.HitEdgeCode !== 4'b1100) begin
      $display("FAIL sof_pixel: collision=%b code=%b required=1/1100", bus.collision,
               bus.HitEdgeCode);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    bit p;
    start_scan();
    sof_tick(p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL b2b_empty1: collision=%b required=0", p);
      fails++;
    end
    sof_tick(p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL b2b_empty2: collision=%b required=0", p);
      fails++;
    end
    hit(31, 31);
    sof_tick(p);
    checks++;
    if (p !== 1'b1 || bus.HitEdgeCode !== 4'b0011) begin
      $display("FAIL b2b_hit: collision=%b code=%b required=1/0011", p, bus.HitEdgeCode);
      fails++;
    end
  endtask

  task automatic test_reset_holdoff();
    bit p;
    start_scan();
    hit(0, 31);
    sof_tick(p);
    checks++;
    if (p !== 1'b1 || bus.HitEdgeCode !== 4'b1001) begin
      $display("FAIL rst_pre_report: collision=%b code=%b required=1/1001", p,
               bus.HitEdgeCode);
      fails++;
    end
    // Asynchronous reset while holding off must clear the code without a clock edge.
    tick();
    resetN = 1'b0;
    #1;
    checks++;
    if (bus.HitEdgeCode !== 4'b0000) begin
      $display("FAIL rst_async_code: got=%b required=0000", bus.HitEdgeCode);
      fails++;
    end
    tick();
    resetN = 1'b1;
    tick();
    // Reset arriving between a reportable SOF and its pulse.
    start_scan();
    drive(0, 0, 1'b1, 1'b1, 1'b1);
    #2;
    resetN = 1'b0;
    tick();
    checks++;
    if (bus.collision !== 1'b0 || bus.HitEdgeCode !== 4'b0000) begin
      $display("FAIL rst_mid_sof: collision=%b code=%b required=0/0000", bus.collision,
               bus.HitEdgeCode);
      fails++;
    end
    idle();
    resetN = 1'b1;
    tick();
    hit(0, 0);
    sof_tick(p);
    checks++;
    if (p !== 1'b0) begin
      $display("FAIL rst_first_sof: collision=%b required=0", p);
      fails++;
    end
    hit(0, 0);
    sof_tick(p);
    checks++;
    if (p !== 1'b1 || bus.HitEdgeCode !== 4'b1100) begin
      $display("FAIL rst_rescan: collision=%b code=%b required=1/1100", p, bus.HitEdgeCode);
      fails++;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    resetN = 1'b0;
    idle();
    test_reset();
    test_first_report();
    test_corners_and_misses();
    test_holdoff();
    test_sof_pixel();
    test_back_to_back();
    test_reset_holdoff();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/smiley_hit_detector.md
# smiley_hit_detector

Producer side of the smiley collision interface: watches the per-pixel drawing requests of the smiley and the bricks and classifies each overlapping pixel by which smiley edge zone it falls in. It accumulates the classifications over one video frame. At the next `startOfFrame` it issues a single-cycle `collision` pulse together with a held 4-bit `HitEdgeCode`, which the smiley motion block consumes. It sits between the VGA object/bitmap blocks and the smiley motion block. An optional hold-off suppresses repeated reports for a configurable number of frames after each hit.

## Interface
Parameters:
- `OBJECT_WIDTH`, 32: smiley width in pixels.
- `OBJECT_HEIGHT`, 32: smiley height in pixels.
- `EDGE_WIDTH`, 4: thickness of each edge zone in pixels; must be ≥1 and ≤ half of the smaller dimension.
- `HOLDOFF_FRAMES`, 2: whole frames ignored after a report; 0 disables hold-off.

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  reset; one clock, asynchronous active-low reset.
- `startOfFrame`  in  1  one-cycle pulse per frame, 30 Hz.
- `offsetX`  in  11 signed  current pixel X relative to smiley top-left.
- `offsetY`  in  11 signed  current pixel Y relative to smiley top-left.
- `smileyDrawingRequest`  in  1  smiley pixel is opaque at the current pixel.
- `brickDrawingRequest`  in  1  a brick is drawn at the current pixel.
- `collision`  out  1  one-cycle pulse reporting a hit in the previous frame.
- `HitEdgeCode`  out  4  {Left, Top, Right, Bottom}; held between reports.

## Operation
- Pixel classification (combinational), valid only when 0 ≤ offsetX < OBJECT_WIDTH and 0 ≤ offsetY < OBJECT_HEIGHT. Pixels outside that range contribute nothing.
  - Left = offsetX < EDGE_WIDTH.
  - Right = offsetX ≥ OBJECT_WIDTH−EDGE_WIDTH.
  - Top = offsetY < EDGE_WIDTH.
  - Bottom = offsetY ≥ OBJECT_HEIGHT−EDGE_WIDTH.
  - Corner pixels set two bits.
  - Interior pixels produce 0000 and are ignored.
- Overlap is `smileyDrawingRequest && brickDrawingRequest`. On overlap, the 4-bit accumulator is ORed with the pixel code.
- States:
  - IDLE: after reset; accumulator forced to 0. At the first `startOfFrame` → SCAN, with no report (partial frame discarded).
  - SCAN: accumulate. At `startOfFrame`:
    - If final accumulator ≠ 0: report, then → HOLDOFF with counter = HOLDOFF_FRAMES (stay in SCAN if HOLDOFF_FRAMES = 0).
    - Accumulator cleared in all cases.
  - HOLDOFF: accumulate but discard. At each `startOfFrame`: clear accumulator, decrement counter; counter reaching 0 → SCAN. No report is issued from HOLDOFF.
- Report: `collision` = 1 for exactly one cycle; `HitEdgeCode` loaded with the final accumulator and held until the next report.
- Counter width: $clog2(HOLDOFF_FRAMES+1), minimum 1 bit.

## Timing
- Reset values: state IDLE, accumulator 0000, counter 0, `collision` 0, `HitEdgeCode` 0000.
- Frame boundary: the pixel present in the `startOfFrame` cycle belongs to the ending frame. "Final accumulator" means the accumulator ORed with that cycle's contribution.
- Latency: `startOfFrame` at cycle t → `collision` high and `HitEdgeCode` valid at cycle t+1 (registered). `collision` is low at t+2.
- The accumulator is 0 in cycle t+1, then begins accumulating the new frame.
- With HOLDOFF_FRAMES = N, after a report at SOF k, frames k … k+N−1 are ignored. The frame starting at SOF k+N is reported at SOF k+N+1.
- Reset mid-frame or mid-hold-off returns to IDLE immediately; no pulse is emitted and the held code is cleared.
- Back-to-back `startOfFrame` pulses on consecutive cycles are legal: each is a frame boundary; an empty frame produces no report.

## Structure
- Package `collision_pkg`:
  - Edge bit indices: LEFT = 3, TOP = 2, RIGHT = 1, BOTTOM = 0.
  - State enum `hit_state_t` {IDLE, SCAN, HOLDOFF}.
  - Default object size constants.
- Sub-module `edge_zone_classifier`: combinational mapping of offsetX/offsetY → 4-bit code plus an in-range flag, parameterized by size and EDGE_WIDTH.
- Top level holds the FSM, accumulator, hold-off counter and output registers.

## Test plan
- Reset, first SOF, overlap at offset (0,10), second SOF → no pulse at first SOF; pulse one cycle after second SOF with HitEdgeCode = 1000.
- Overlaps at (31,0) and (15,31) in one frame → single pulse, HitEdgeCode = 0111, held until the next report.
- Interior overlap at (15,15) only, or overlap with smileyDrawingRequest = 0 → no pulse, HitEdgeCode unchanged.
- HOLDOFF_FRAMES = 2, bottom overlap at (10,30) every frame → pulses at SOF k, k+3, k+6; HitEdgeCode = 0001.
- Overlap at (0,0) present exactly in the SOF cycle → counted in the ending frame; pulse next cycle with 1100.
- resetN asserted during HOLDOFF, between SOF and pulse → collision 0, code 0000, IDLE; the first SOF after reset produces no pulse.
